// File: rtl/cpu_run_controller.sv
// cpu_run_controller
//   Sequencer for the 4-bit datapath. It pulses set_pc for INIT_CYCLES,
//   then advances the datapath one instruction per clock (RUN) or exactly
//   once (STEP), and parks in HALT on limit, overflow, stop or step done.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   start        begin run (IDLE/HALT only): re-init PC, clear counter
//   step         single instruction then halt (IDLE/HALT only)
//   stop         halt request while running
//   halt_on_ovf  enable halt on alu_ovf during an executed RUN cycle
//   max_instr    RUN instruction limit, 0 = unlimited
//   alu_ovf      datapath overflow, meaningful while dp_en is high
//   set_pc       datapath PC-load control (INIT)
//   dp_en        datapath advance enable (INIT, RUN, STEP)
//   busy         INIT, RUN or STEP
//   halted       HALT
//   halt_cause   0 none/step, 1 overflow, 2 limit, 3 stop
//   instr_count  instructions executed since the last INIT (saturating)
module cpu_run_controller #(
    parameter int CNT_W       = 8,
    parameter int INIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic             stop,
    input  logic             halt_on_ovf,
    input  logic [CNT_W-1:0] max_instr,
    input  logic             alu_ovf,
    output logic             set_pc,
    output logic             dp_en,
    output logic             busy,
    output logic             halted,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_STEP,
        S_HALT
    } state_t;

    localparam int            IW        = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);

    state_t           state, state_nx;
    logic             mode_step, mode_step_nx;
    logic [IW-1:0]    init_cnt, init_cnt_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic [1:0]       cause_nx;

    // Count one wider so the limit compare never aliases when the counter
    // sits at all-ones.
    logic [CNT_W:0]   cnt_p1;
    logic [CNT_W-1:0] cnt_sat;
    logic             lim_hit;

    assign cnt_p1  = {1'b0, instr_count} + (CNT_W+1)'(1);
    assign cnt_sat = (&instr_count) ? instr_count : cnt_p1[CNT_W-1:0];
    assign lim_hit = (max_instr != '0) && (cnt_p1 == {1'b0, max_instr});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            mode_step   <= 1'b0;
            init_cnt    <= '0;
            instr_count <= '0;
            halt_cause  <= 2'd0;
        end else begin
            state       <= state_nx;
            mode_step   <= mode_step_nx;
            init_cnt    <= init_cnt_nx;
            instr_count <= cnt_nx;
            halt_cause  <= cause_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        mode_step_nx = mode_step;
        init_cnt_nx  = init_cnt;
        cnt_nx       = instr_count;
        cause_nx     = halt_cause;
        case (state)
            S_IDLE: begin
                // start outranks step; both enter INIT, mode decides exit
                if (start || step) begin
                    state_nx     = S_INIT;
                    mode_step_nx = !start;
                    init_cnt_nx  = '0;
                    cnt_nx       = '0;
                    cause_nx     = 2'd0;
                end
            end
            S_INIT: begin
                if (init_cnt == INIT_LAST)
                    state_nx = mode_step ? S_STEP : S_RUN;
                else
                    init_cnt_nx = init_cnt + IW'(1);
            end
            S_RUN: begin
                // the triggering instruction still counts
                cnt_nx = cnt_sat;
                if (halt_on_ovf && alu_ovf) begin
                    state_nx = S_HALT;
                    cause_nx = 2'd1;
                end else if (lim_hit) begin
                    state_nx = S_HALT;
                    cause_nx = 2'd2;
                end else if (stop) begin
                    state_nx = S_HALT;
                    cause_nx = 2'd3;
                end
            end
            S_STEP: begin
                cnt_nx   = cnt_sat;
                cause_nx = 2'd0;
                state_nx = S_HALT;
            end
            S_HALT: begin
                if (start) begin
                    state_nx     = S_INIT;
                    mode_step_nx = 1'b0;
                    init_cnt_nx  = '0;
                    cnt_nx       = '0;
                    cause_nx     = 2'd0;
                end else if (step) begin
                    // step from HALT skips re-init; count carries on
                    state_nx = S_STEP;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs depend only on registered state.
    assign set_pc = (state == S_INIT);
    assign dp_en  = (state == S_INIT) || (state == S_RUN) || (state == S_STEP);
    assign busy   = dp_en;
    assign halted = (state == S_HALT);

endmodule

// File: tb/tb_cpu_run_controller.sv
module tb_cpu_run_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, step = 1'b0, stop = 1'b0;
    logic       halt_on_ovf = 1'b0, alu_ovf = 1'b0;
    logic [7:0] max_instr = 8'd0;

    logic       set_pc, dp_en, busy, halted;
    logic [1:0] halt_cause;
    logic [7:0] instr_count;

    logic       set_pc4, dp_en4, busy4, halted4;
    logic [1:0] halt_cause4;
    logic [3:0] instr_count4;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    cpu_run_controller #(.CNT_W(8), .INIT_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step(step), .stop(stop),
        .halt_on_ovf(halt_on_ovf), .max_instr(max_instr), .alu_ovf(alu_ovf),
        .set_pc(set_pc), .dp_en(dp_en), .busy(busy), .halted(halted),
        .halt_cause(halt_cause), .instr_count(instr_count)
    );

    cpu_run_controller #(.CNT_W(4), .INIT_CYCLES(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .step(step), .stop(stop),
        .halt_on_ovf(halt_on_ovf), .max_instr(max_instr[3:0]), .alu_ovf(alu_ovf),
        .set_pc(set_pc4), .dp_en(dp_en4), .busy(busy4), .halted(halted4),
        .halt_cause(halt_cause4), .instr_count(instr_count4)
    );

    // advance one clock; outputs are then stable for sampling and inputs
    // driven here are captured by the following edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 0; step = 0; stop = 0; alu_ovf = 0;
        halt_on_ovf = 0; max_instr = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    // wait in RUN until instr_count reaches target; flags a timeout
    task automatic wait_count(input logic [7:0] target, input string nm);
        int k;
        for (k = 0; k < 300 && instr_count !== target; k++) tick();
        if (instr_count !== target) begin
            n_total++;
            $display("FAIL %s timeout: instr_count=%0d required %0d", nm, instr_count, target);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({set_pc, dp_en, busy, halted, halt_cause, instr_count} !== 14'd0)
            $display("FAIL reset_outputs got %b required 0",
                     {set_pc, dp_en, busy, halted, halt_cause, instr_count});
        else n_pass++;
    endtask

    task automatic test_limit();
        int n_set, n_dp;
        n_set = 0; n_dp = 0;
        max_instr = 8'd16;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (set_pc === 1'b1) n_set++;
            if (dp_en === 1'b1) n_dp++;
            tick();
        end
        n_total++;
        if (n_set !== 1) $display("FAIL limit_set_pc_cycles got %0d required 1", n_set);
        else n_pass++;
        n_total++;
        if (n_dp !== 17) $display("FAIL limit_dp_en_cycles got %0d required 17", n_dp);
        else n_pass++;
        n_total++;
        if (halted !== 1'b1 || halt_cause !== 2'd2 || instr_count !== 8'd16)
            $display("FAIL limit_halt got halted=%b cause=%0d cnt=%0d required 1/2/16",
                     halted, halt_cause, instr_count);
        else n_pass++;
    endtask

    task automatic test_stop();
        max_instr = 8'd0;
        start = 1'b1; tick(); start = 1'b0;
        wait_count(8'd4, "stop_wait");
        stop = 1'b1; tick(); stop = 1'b0;
        n_total++;
        if (halted !== 1'b1 || halt_cause !== 2'd3 || instr_count !== 8'd5)
            $display("FAIL stop_halt got halted=%b cause=%0d cnt=%0d required 1/3/5",
                     halted, halt_cause, instr_count);
        else n_pass++;
    endtask

    task automatic test_ovf();
        max_instr = 8'd10; halt_on_ovf = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        wait_count(8'd2, "ovf_wait");
        alu_ovf = 1'b1; stop = 1'b1; tick(); alu_ovf = 1'b0; stop = 1'b0;
        n_total++;
        if (halted !== 1'b1 || halt_cause !== 2'd1 || instr_count !== 8'd3)
            $display("FAIL ovf_priority got halted=%b cause=%0d cnt=%0d required 1/1/3",
                     halted, halt_cause, instr_count);
        else n_pass++;
        // same stimulus, overflow halting disabled: stop still seen, so
        // drive only alu_ovf to check it is ignored
        halt_on_ovf = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        wait_count(8'd2, "ovf_off_wait");
        alu_ovf = 1'b1; tick(); alu_ovf = 1'b0;
        n_total++;
        if (halted !== 1'b0 || dp_en !== 1'b1)
            $display("FAIL ovf_ignored got halted=%b dp_en=%b required 0/1", halted, dp_en);
        else n_pass++;
        for (int i = 0; i < 20 && halted !== 1'b1; i++) tick();
        n_total++;
        if (halted !== 1'b1 || halt_cause !== 2'd2 || instr_count !== 8'd10)
            $display("FAIL ovf_off_limit got halted=%b cause=%0d cnt=%0d required 1/2/10",
                     halted, halt_cause, instr_count);
        else n_pass++;
    endtask

    task automatic test_step();
        int n_set;
        n_set = 0;
        do_reset();
        step = 1'b1; tick(); step = 1'b0;
        n_total++;
        if (set_pc !== 1'b1) $display("FAIL step_init set_pc=%b required 1", set_pc);
        else n_pass++;
        tick();
        n_total++;
        if (dp_en !== 1'b1 || set_pc !== 1'b0 || halted !== 1'b0)
            $display("FAIL step_exec got dp_en=%b set_pc=%b halted=%b required 1/0/0",
                     dp_en, set_pc, halted);
        else n_pass++;
        tick();
        n_total++;
        if (halted !== 1'b1 || halt_cause !== 2'd0 || instr_count !== 8'd1)
            $display("FAIL step_halt got halted=%b cause=%0d cnt=%0d required 1/0/1",
                     halted, halt_cause, instr_count);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step = 1'b1; tick(); step = 1'b0;
            if (set_pc === 1'b1) n_set++;
            tick();
            if (set_pc === 1'b1) n_set++;
        end
        n_total++;
        if (instr_count !== 8'd4 || n_set !== 0 || halted !== 1'b1)
            $display("FAIL step_repeat got cnt=%0d set_pc_cycles=%0d halted=%b required 4/0/1",
                     instr_count, n_set, halted);
        else n_pass++;
        start = 1'b1; tick(); start = 1'b0;
        n_total++;
        if (set_pc !== 1'b1 || instr_count !== 8'd0)
            $display("FAIL step_restart got set_pc=%b cnt=%0d required 1/0", set_pc, instr_count);
        else n_pass++;
    endtask

    task automatic test_saturate();
        do_reset();
        max_instr = 8'd0;
        start = 1'b1; tick(); start = 1'b0;
        wait_count(8'd20, "sat_wait");
        stop = 1'b1; tick(); stop = 1'b0;
        n_total++;
        if (instr_count4 !== 4'd15 || halted4 !== 1'b1 || halt_cause4 !== 2'd3)
            $display("FAIL sat_cnt4 got cnt=%0d halted=%b cause=%0d required 15/1/3",
                     instr_count4, halted4, halt_cause4);
        else n_pass++;
        n_total++;
        if (instr_count !== 8'd21)
            $display("FAIL sat_cnt8 got cnt=%0d required 21", instr_count);
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        int n_dp;
        n_dp = 0;
        max_instr = 8'd0;
        start = 1'b1; tick(); start = 1'b0;
        wait_count(8'd7, "rst_wait");
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({set_pc, dp_en, busy, halted, halt_cause, instr_count} !== 14'd0)
            $display("FAIL async_reset got %b required 0",
                     {set_pc, dp_en, busy, halted, halt_cause, instr_count});
        else n_pass++;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (dp_en !== 1'b0) n_dp++;
        end
        n_total++;
        if (n_dp !== 0) $display("FAIL post_reset_idle dp_en cycles=%0d required 0", n_dp);
        else n_pass++;
        start = 1'b1; step = 1'b1; tick(); start = 1'b0; step = 1'b0;
        tick(); tick(); tick();
        n_total++;
        if (dp_en !== 1'b1 || halted !== 1'b0 || instr_count !== 8'd2)
            $display("FAIL start_over_step got dp_en=%b halted=%b cnt=%0d required 1/0/2",
                     dp_en, halted, instr_count);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_limit();
        test_stop();
        test_ovf();
        test_step();
        test_saturate();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
